// File: rtl/far_ptr_sync_if.sv
// Commit handshake between far_ptr_sync and the prefetcher.
// master: out_valid/out_seg/out_off out, out_ready in; slave: the mirror.
interface far_ptr_sync_if #(
    parameter int SEG_WIDTH = 16,
    parameter int OFF_WIDTH = 16
);
    logic                 out_valid;
    logic                 out_ready;
    logic [SEG_WIDTH-1:0] out_seg;
    logic [OFF_WIDTH-1:0] out_off;

    modport master (
        output out_valid,
        output out_seg,
        output out_off,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_seg,
        input  out_off,
        output out_ready
    );
endinterface

// File: rtl/far_ptr_sync.sv
// Far-pointer (segment:offset) staging and commit queue for the prefetcher.
// Ports: clk, reset (async, active-high); seg_update/off_update with
// new_seg/new_off stage writes; seg_in/off_in are architectural values;
// propagate commits the staged pair, flush discards everything; cmt is the
// commit handshake (out_valid/out_ready/out_seg/out_off); busy = staging
// pending, overflow = sticky drop flag, count = queue occupancy.
// Macro FAR_PTR_SYNC_FORWARD_EN: commit bypasses an empty queue to out_*
// in the same cycle.
module far_ptr_sync #(
    parameter int SEG_WIDTH = 16,
    parameter int OFF_WIDTH = 16,
    parameter int DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seg_update,
    input  logic                   off_update,
    input  logic [SEG_WIDTH-1:0]   new_seg,
    input  logic [OFF_WIDTH-1:0]   new_off,
    input  logic [SEG_WIDTH-1:0]   seg_in,
    input  logic [OFF_WIDTH-1:0]   off_in,
    input  logic                   propagate,
    input  logic                   flush,
    far_ptr_sync_if.master         cmt,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic                 seg_pend, off_pend;
    logic [SEG_WIDTH-1:0] seg_stg;
    logic [OFF_WIDTH-1:0] off_stg;
    logic [SEG_WIDTH-1:0] mem_seg [DEPTH];
    logic [OFF_WIDTH-1:0] mem_off [DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;

    logic                 commit, empty, full;
    logic                 pop, push, drop;
    logic [SEG_WIDTH-1:0] commit_seg;
    logic [OFF_WIDTH-1:0] commit_off;

    always_comb begin
        // Gating with reset keeps the forwarding path quiet during reset.
        commit = !reset && propagate &&
                 (seg_pend || off_pend || seg_update || off_update);
        commit_seg = seg_update ? new_seg :
                     seg_pend   ? seg_stg : seg_in;
        commit_off = off_update ? new_off :
                     off_pend   ? off_stg : off_in;
        empty = (count == '0);
        full  = (count == FULL_CNT);
        busy  = seg_pend || off_pend;
        pop   = !empty && cmt.out_ready;
`ifdef FAR_PTR_SYNC_FORWARD_EN
        // A bypassed pair taken by the consumer is never stored.
        push = commit && !(empty && cmt.out_ready) && (!full || pop);
        cmt.out_valid = !empty || commit;
        cmt.out_seg = !empty ? mem_seg[rd_ptr] :
                      commit ? commit_seg : '0;
        cmt.out_off = !empty ? mem_off[rd_ptr] :
                      commit ? commit_off : '0;
`else
        push = commit && (!full || pop);
        cmt.out_valid = !empty;
        cmt.out_seg = empty ? '0 : mem_seg[rd_ptr];
        cmt.out_off = empty ? '0 : mem_off[rd_ptr];
`endif
        drop = commit && full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_pend <= 1'b0;
            off_pend <= 1'b0;
        end else if (flush || commit) begin
            seg_pend <= 1'b0;
            off_pend <= 1'b0;
        end else if (!propagate) begin
            if (seg_update) seg_pend <= 1'b1;
            if (off_update) off_pend <= 1'b1;
        end
    end

    // Data registers are only observed while a flag or entry is valid.
    always_ff @(posedge clk) begin
        if (seg_update && !propagate) seg_stg <= new_seg;
        if (off_update && !propagate) off_stg <= new_off;
        if (push && !flush) begin
            mem_seg[wr_ptr] <= commit_seg;
            mem_off[wr_ptr] <= commit_off;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: doc/far_ptr_sync.md
FAR_PTR_SYNC -- requirements
Module: far_ptr_sync

Interface
REQ-001 SHALL have parameter SEG_WIDTH, default 16, width of segment value.
REQ-002 SHALL have parameter OFF_WIDTH, default 16, width of offset value.
REQ-003 SHALL have parameter DEPTH, default 2, commit queue entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports seg_update / off_update  input  1 each  microcode writes segment / offset this cycle.
REQ-007 SHALL have ports new_seg  input  SEG_WIDTH and new_off  input  OFF_WIDTH  values written.
REQ-008 SHALL have ports seg_in  input  SEG_WIDTH and off_in  input  OFF_WIDTH  current architectural values.
REQ-009 SHALL have port propagate  input  1  microinstruction completes; commit staged pair.
REQ-010 SHALL have port flush  input  1  discard staging and queue.
REQ-011 SHALL have ports out_valid  output  1, out_ready  input  1  commit handshake to prefetcher.
REQ-012 SHALL have ports out_seg  output  SEG_WIDTH and out_off  output  OFF_WIDTH  head commit pair.
REQ-013 SHALL have ports busy  output  1 (staging pending), overflow  output  1 (sticky drop flag), count  output  clog2(DEPTH)+1 (queue occupancy).

Function
REQ-014 Staging: segment and offset each own a pending flag plus register; update with propagate low captures value, sets flag; repeated updates last-write-wins.
REQ-015 Commit condition: propagate high and (either pending flag or either update input) high; otherwise propagate is a no-op.
REQ-016 Commit pair per field: update input this cycle ? new value : pending ? staged value : *_in; same-cycle update is folded into the commit, not staged.
REQ-017 Commit clears both pending flags and pushes pair into queue at tail; busy = OR of pending flags.
REQ-018 out_valid = queue non-empty; out_seg/out_off = head entry; driven 0 when empty.
REQ-019 Pop when out_valid and out_ready; strict FIFO order; pointers wrap modulo DEPTH.
REQ-020 Push when full and no pop same cycle: commit dropped, queue unchanged, overflow set to 1 until reset or flush.
REQ-021 Push and pop same cycle when full: both performed, count unchanged, no overflow.
REQ-022 flush: next cycle queue empty, count 0, pending flags 0, overflow 0; flush overrides any same-cycle update, commit or pop.
REQ-023 Without forwarding, commit becomes visible on out_valid one cycle after propagate.

Reset
REQ-024 On reset: pending flags 0, queue empty, count 0, out_valid 0, out_seg/out_off 0, busy 0, overflow 0; reset mid-commit discards it.
REQ-025 Staged data registers need not be reset; never visible while flags clear.

Configuration
REQ-026 Macro FAR_PTR_SYNC_FORWARD_EN SHALL select zero-latency forwarding.
REQ-027 Defined: queue empty and commit occurs -> out_valid high same cycle with commit pair; if out_ready also high, pair consumed and not stored, count stays 0.
REQ-028 Undefined: behaviour per REQ-023; no combinational path from propagate/update inputs to out_*.

Verification
REQ-029 off_update new_off=0x1234, next cycle seg_update new_seg=0xF000, next propagate -> one commit F000:1234, out_valid next cycle (same cycle if FORWARD_EN).
REQ-030 seg_in=0x0100, off_in=0x0010, off_update new_off=0x0020 with propagate -> commit 0100:0020, busy never high.
REQ-031 DEPTH=2, out_ready=0, three commits A,B,C -> count=2, overflow=1, pops yield A then B; C lost.
REQ-032 Full queue, commit with out_ready=1 same cycle -> count stays 2, overflow 0, order preserved.
REQ-033 Staged offset plus 1 queued entry, assert flush with propagate -> next cycle out_valid 0, busy 0, count 0, no commit.
REQ-034 Assert reset during propagate with pending updates -> all outputs 0 while reset high; first commit after release carries only post-reset data.
